sha256_work_sequencer: RTL and testbench

SHA256_WORK_SEQUENCER -- requirements
Module: sha256_work_sequencer

---
 rtl/sha256_work_sequencer_pkg.sv | 44 ++++
 rtl/sha256_tag_delay.sv | 46 ++++
 rtl/sha256_work_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sha256_work_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_work_sequencer_pkg.sv
// ============================================================================
// Module      : sha256_work_sequencer_pkg
// Description : Shared types and constants for the SHA-256 work sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_work_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int c_word_w    = 32;
   localparam int c_state_w   = 256;
   localparam int c_block_w   = 512;
   localparam int c_data_w    = 96;

   localparam int c_word_nonce = 3;
   localparam int c_word_pad   = 4;
   localparam int c_word_len   = 15;

   localparam logic [31:0] c_pad_word = 32'h80000000;
   localparam logic [31:0] c_len_word = 32'd640;

   // Second block of an 80-byte header: 3 data words, nonce, then padding.
   function automatic logic [c_block_w-1:0] build_block(
      input logic [c_data_w-1:0] data,
      input logic [c_word_w-1:0] nonce
   );
      logic [c_block_w-1:0] blk;
      blk                              = '0;
      blk[c_data_w-1:0]                = data;
      blk[c_word_nonce*c_word_w +: 32] = nonce;
      blk[c_word_pad*c_word_w +: 32]   = c_pad_word;
      blk[c_word_len*c_word_w +: 32]   = c_len_word;
      return blk;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_tag_delay.sv
// ============================================================================
// Module      : sha256_tag_delay
// Description : Fixed-depth {valid, nonce} shift line aligned to hash latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_tag_delay
   import sha256_work_sequencer_pkg::*;
#(
   parameter int DEPTH   = 65,
   parameter int NONCE_W = c_word_w
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   input  logic [NONCE_W-1:0] i_nonce,
   output logic               o_valid,
   output logic [NONCE_W-1:0] o_nonce
);

   logic [DEPTH-1:0]   r_valid;
   logic [NONCE_W-1:0] r_nonce [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_nonce[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_nonce[0] <= i_nonce;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_nonce[i] <= r_nonce[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_nonce = r_nonce[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sha256_work_sequencer.sv
// ============================================================================
// Module      : sha256_work_sequencer
// Description : Issues a nonce range to a looped SHA-256 transform and reports
//               nonces whose top hash word is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_work_sequencer
   import sha256_work_sequencer_pkg::*;
#(
   parameter int LOOP         = 4,
   parameter int HASH_LATENCY = 65
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 work_valid,
   output logic                 work_ready,
   input  logic [c_state_w-1:0] work_midstate,
   input  logic [c_data_w-1:0]  work_data,
   input  logic [31:0]          nonce_start,
   input  logic [31:0]          nonce_end,
   output logic                 feedback,
   output logic [5:0]           cnt,
   output logic [c_state_w-1:0] rx_state,
   output logic [c_block_w-1:0] rx_input,
   input  logic [c_state_w-1:0] tx_hash,
   output logic                 golden_valid,
   output logic [31:0]          golden_nonce,
   output logic                 busy,
   output logic                 done
);

   localparam int         c_out_w    = $clog2(HASH_LATENCY + 2);
   localparam logic [5:0] c_cnt_last = 6'(LOOP - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [5:0]           r_cnt;
   logic [31:0]          r_nonce;
   logic [31:0]          r_nonce_end;
   logic [c_state_w-1:0] r_midstate;
   logic [c_data_w-1:0]  r_data;
   logic [c_out_w-1:0]   r_outstanding;
   logic                 r_golden_valid;
   logic [31:0]          r_golden_nonce;

   logic                 w_accept;
   logic                 w_issue;
   logic                 w_exit_valid;
   logic [31:0]          w_exit_nonce;
   logic                 w_hit;
   logic                 w_unused_hash;

   assign w_accept      = (r_state == ST_IDLE) && work_valid;
   assign w_hit         = w_exit_valid && (tx_hash[255:224] == 32'd0);
   assign w_unused_hash = ^tx_hash[223:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      work_ready   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      feedback     = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            work_ready = 1'b1;
            if (work_valid) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy     = 1'b1;
            feedback = (r_cnt != 6'd0);
            w_issue  = (r_cnt == 6'd0);
            if (w_issue && (r_nonce == r_nonce_end)) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy     = 1'b1;
            feedback = (r_cnt != 6'd0);
            if (r_outstanding == '0) begin
               done         = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt          <= 6'd0;
         r_nonce        <= 32'd0;
         r_nonce_end    <= 32'd0;
         r_midstate     <= '0;
         r_data         <= '0;
         r_outstanding  <= '0;
         r_golden_valid <= 1'b0;
         r_golden_nonce <= 32'd0;
      end else begin
         // Round counter parks at zero in IDLE so a new job starts on an issue.
         if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE) || (r_cnt == c_cnt_last)) begin
            r_cnt <= 6'd0;
         end else begin
            r_cnt <= r_cnt + 6'd1;
         end

         if (w_accept) begin
            r_midstate  <= work_midstate;
            r_data      <= work_data;
            r_nonce     <= nonce_start;
            r_nonce_end <= nonce_end;
         end else if (w_issue) begin
            r_nonce <= r_nonce + 32'd1;
         end

         case ({w_issue, w_exit_valid})
            2'b10:   r_outstanding <= r_outstanding + c_out_w'(1);
            2'b01:   r_outstanding <= r_outstanding - c_out_w'(1);
            default: r_outstanding <= r_outstanding;
         endcase

         r_golden_valid <= w_hit;
         if (w_hit) begin
            r_golden_nonce <= w_exit_nonce;
         end
      end
   end

   sha256_tag_delay #(
      .DEPTH   (HASH_LATENCY),
      .NONCE_W (32)
   ) u_tag_delay (
      .clk     (clk),
      .rst     (reset),
      .i_valid (w_issue),
      .i_nonce (r_nonce),
      .o_valid (w_exit_valid),
      .o_nonce (w_exit_nonce)
   );

   assign cnt          = r_cnt;
   assign rx_state     = r_midstate;
   assign rx_input     = build_block(r_data, r_nonce);
   assign golden_valid = r_golden_valid;
   assign golden_nonce = r_golden_nonce;

endmodule

`default_nettype wire

// File: tb/tb_sha256_work_sequencer.sv
// ============================================================================
// Module      : tb_sha256_work_sequencer
// Description : Self-checking bench; expected schedule derived from job arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_work_sequencer;

   localparam int LOOP = 4;
   localparam int LAT  = 65;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         work_valid = 1'b0;
   logic         work_ready;
   logic [255:0] work_midstate = '0;
   logic [95:0]  work_data = '0;
   logic [31:0]  nonce_start = '0;
   logic [31:0]  nonce_end = '0;
   logic         feedback;
   logic [5:0]   cnt;
   logic [255:0] rx_state;
   logic [511:0] rx_input;
   logic [255:0] tx_hash = '0;
   logic         golden_valid;
   logic [31:0]  golden_nonce;
   logic         busy;
   logic         done;

   int          n_vec = 0;
   int          n_bad = 0;
   bit          hit_tab [64];
   logic [31:0] exp_gn = '0;
   int          obs_done_at;
   int          obs_gold_cnt;
   logic [31:0] obs_gold_last;
   logic [31:0] obs_issues [$];

   sha256_work_sequencer #(.LOOP(LOOP), .HASH_LATENCY(LAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .work_valid    (work_valid),
      .work_ready    (work_ready),
      .work_midstate (work_midstate),
      .work_data     (work_data),
      .nonce_start   (nonce_start),
      .nonce_end     (nonce_end),
      .feedback      (feedback),
      .cnt           (cnt),
      .rx_state      (rx_state),
      .rx_input      (rx_input),
      .tx_hash       (tx_hash),
      .golden_valid  (golden_valid),
      .golden_nonce  (golden_nonce),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] exp_block(input logic [95:0] d, input logic [31:0] nn);
      logic [511:0] b;
      for (int w = 0; w < 16; w++) begin
         logic [31:0] v;
         if (w < 3)       v = d[w*32 +: 32];
         else if (w == 3) v = nn;
         else if (w == 4) v = 32'h80000000;
         else if (w == 15) v = 32'd640;
         else             v = 32'd0;
         b[w*32 +: 32] = v;
      end
      return b;
   endfunction

   task automatic drive_hash(input bit zero_top);
      for (int w = 0; w < 7; w++) tx_hash[w*32 +: 32] = $urandom;
      tx_hash[255:224] = zero_top ? 32'd0 : ($urandom | 32'd1);
   endtask

   // One job from accept to the first IDLE cycle after done; every cycle is checked.
   task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] e, input bit hold);
      logic [255:0] mid;
      logic [95:0]  dat;
      int           n, d, k, ph;
      bit           in_job, is_issue, is_exit, exp_gv;
      logic [5:0]   exp_cnt;
      for (int w = 0; w < 8; w++) mid[w*32 +: 32] = $urandom;
      for (int w = 0; w < 3; w++) dat[w*32 +: 32] = $urandom;
      n = int'(e - s) + 1;
      d = 2 + (n - 1) * LOOP + LAT;
      obs_issues.delete();
      obs_gold_cnt  = 0;
      obs_gold_last = '0;
      obs_done_at   = -1;
      work_midstate = mid;
      work_data     = dat;
      nonce_start   = s;
      nonce_end     = e;
      work_valid    = 1'b1;
      drive_hash(1'b0);
      n_vec++;
      if (work_ready !== 1'b1) begin
         n_bad++; $display("FAIL %s accept_ready: got %b want 1", tag, work_ready);
      end
      for (int c = 1; c <= d + 1; c++) begin
         @(posedge clk); #1;
         if (hold) begin
            work_midstate = {8{$urandom}};
            work_data     = {3{$urandom}};
            nonce_start   = $urandom;
            nonce_end     = $urandom;
         end else begin
            work_valid = 1'b0;
         end
         in_job   = (c <= d);
         ph       = c - 1;
         is_issue = in_job && (ph % LOOP == 0) && (ph / LOOP < n);
         exp_cnt  = in_job ? 6'(ph % LOOP) : 6'd0;
         k        = c - 2 - LAT;
         exp_gv   = (k >= 0) && (k % LOOP == 0) && (k / LOOP < n) && hit_tab[k / LOOP];
         if (exp_gv) exp_gn = s + 32'(k / LOOP);

         n_vec++;
         if (busy !== in_job) begin
            n_bad++; $display("FAIL %s busy c=%0d: got %b want %b", tag, c, busy, in_job);
         end
         n_vec++;
         if (work_ready !== !in_job) begin
            n_bad++; $display("FAIL %s work_ready c=%0d: got %b want %b", tag, c, work_ready, !in_job);
         end
         n_vec++;
         if (cnt !== exp_cnt) begin
            n_bad++; $display("FAIL %s cnt c=%0d: got %0d want %0d", tag, c, cnt, exp_cnt);
         end
         n_vec++;
         if (feedback !== (exp_cnt != 6'd0)) begin
            n_bad++; $display("FAIL %s feedback c=%0d: got %b want %b", tag, c, feedback, exp_cnt != 6'd0);
         end
         n_vec++;
         if (done !== (c == d)) begin
            n_bad++; $display("FAIL %s done c=%0d: got %b want %b", tag, c, done, c == d);
         end
         n_vec++;
         if (golden_valid !== exp_gv) begin
            n_bad++; $display("FAIL %s golden_valid c=%0d: got %b want %b", tag, c, golden_valid, exp_gv);
         end
         n_vec++;
         if (golden_nonce !== exp_gn) begin
            n_bad++; $display("FAIL %s golden_nonce c=%0d: got %h want %h", tag, c, golden_nonce, exp_gn);
         end
         if (is_issue) begin
            obs_issues.push_back(rx_input[127:96]);
            n_vec++;
            if (rx_input !== exp_block(dat, s + 32'(ph / LOOP))) begin
               n_bad++; $display("FAIL %s rx_input c=%0d: got %h want %h", tag, c, rx_input, exp_block(dat, s + 32'(ph / LOOP)));
            end
            n_vec++;
            if (rx_state !== mid) begin
               n_bad++; $display("FAIL %s rx_state c=%0d: got %h want %h", tag, c, rx_state, mid);
            end
         end
         if (golden_valid === 1'b1) begin
            obs_gold_cnt++;
            obs_gold_last = golden_nonce;
         end
         if (done === 1'b1 && obs_done_at < 0) obs_done_at = c;

         k       = c - 1 - LAT;
         is_exit = (k >= 0) && (k % LOOP == 0) && (k / LOOP < n);
         if (is_exit) drive_hash(hit_tab[k / LOOP]);
         else         drive_hash(1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (work_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", work_ready); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++;
      if (cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      n_vec++;
      if (feedback !== 1'b0) begin n_bad++; $display("FAIL reset_feedback: got %b want 0", feedback); end
      n_vec++;
      if (golden_valid !== 1'b0) begin n_bad++; $display("FAIL reset_golden_valid: got %b want 0", golden_valid); end
      n_vec++;
      if (golden_nonce !== 32'd0) begin n_bad++; $display("FAIL reset_golden_nonce: got %h want 0", golden_nonce); end
      n_vec++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_vec++;
      if (rx_input[127:96] !== 32'd0) begin n_bad++; $display("FAIL reset_nonce: got %h want 0", rx_input[127:96]); end
      reset = 1'b0;
      exp_gn = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      foreach (hit_tab[i]) hit_tab[i] = 1'b0;
      run_job("single", 32'd5, 32'd5, 1'b0);
      n_vec++;
      if (obs_done_at !== 1 + 66) begin n_bad++; $display("FAIL single_done_at: got %0d want %0d", obs_done_at, 67); end
      n_vec++;
      if (obs_issues.size() != 1 || obs_issues[0] !== 32'd5) begin
         n_bad++; $display("FAIL single_issues: got %0d issues want 1 of nonce 5", obs_issues.size());
      end
   endtask

   task automatic test_sequence;
      foreach (hit_tab[i]) hit_tab[i] = 1'b0;
      run_job("sequence", 32'd0, 32'd3, 1'b0);
      n_vec++;
      if (obs_done_at !== 13 + 66) begin n_bad++; $display("FAIL sequence_done_at: got %0d want %0d", obs_done_at, 79); end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (i >= obs_issues.size() || obs_issues[i] !== 32'(i)) begin
            n_bad++; $display("FAIL sequence_issue%0d: got %h want %h", i, (i < obs_issues.size()) ? obs_issues[i] : 32'hx, i);
         end
      end
      n_vec++;
      if (obs_gold_cnt != 0) begin n_bad++; $display("FAIL sequence_gold_cnt: got %0d want 0", obs_gold_cnt); end
   endtask

   task automatic test_golden;
      foreach (hit_tab[i]) hit_tab[i] = 1'b0;
      hit_tab[2] = 1'b1;
      run_job("golden", 32'd0, 32'd3, 1'b0);
      n_vec++;
      if (obs_gold_cnt != 1) begin n_bad++; $display("FAIL golden_count: got %0d want 1", obs_gold_cnt); end
      n_vec++;
      if (obs_gold_last !== 32'd2) begin n_bad++; $display("FAIL golden_nonce_val: got %h want 2", obs_gold_last); end
   endtask

   task automatic test_wrap;
      logic [31:0] exp_list [4];
      exp_list[0] = 32'hFFFFFFFE; exp_list[1] = 32'hFFFFFFFF; exp_list[2] = 32'd0; exp_list[3] = 32'd1;
      foreach (hit_tab[i]) hit_tab[i] = 1'b0;
      hit_tab[1] = 1'b1;
      run_job("wrap", 32'hFFFFFFFE, 32'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (i >= obs_issues.size() || obs_issues[i] !== exp_list[i]) begin
            n_bad++; $display("FAIL wrap_issue%0d: got %h want %h", i, (i < obs_issues.size()) ? obs_issues[i] : 32'hx, exp_list[i]);
         end
      end
      n_vec++;
      if (obs_gold_last !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_golden: got %h want ffffffff", obs_gold_last); end
   endtask

   task automatic test_random;
      logic [31:0] s, e;
      int          nhit;
      for (int j = 0; j < 6; j++) begin
         s    = ($urandom_range(0, 2) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 5))) : 32'($urandom);
         e    = s + 32'($urandom_range(0, 9));
         nhit = 0;
         for (int i = 0; i < 64; i++) begin
            hit_tab[i] = ($urandom_range(0, 2) == 0);
            if (hit_tab[i] && i <= int'(e - s)) nhit++;
         end
         run_job("random", s, e, 1'b0);
         n_vec++;
         if (obs_gold_cnt != nhit) begin n_bad++; $display("FAIL random_gold_cnt job%0d: got %0d want %0d", j, obs_gold_cnt, nhit); end
      end
   endtask

   task automatic test_back_to_back;
      foreach (hit_tab[i]) hit_tab[i] = 1'b0;
      hit_tab[0] = 1'b1;
      run_job("b2b_first", 32'd10, 32'd12, 1'b1);
      run_job("b2b_second", 32'd40, 32'd41, 1'b0);
      n_vec++;
      if (obs_gold_last !== 32'd40) begin n_bad++; $display("FAIL b2b_golden: got %h want 28", obs_gold_last); end
   endtask

   task automatic test_reset_midjob;
      work_midstate = {8{$urandom}};
      work_data     = {3{$urandom}};
      nonce_start   = 32'd100;
      nonce_end     = 32'd140;
      work_valid    = 1'b1;
      tx_hash       = '0;
      @(posedge clk); #1;
      work_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
      n_vec++;
      if (golden_nonce !== 32'd0) begin n_bad++; $display("FAIL midreset_gnonce: got %h want 0", golden_nonce); end
      @(posedge clk); #1;
      reset  = 1'b0;
      exp_gn = '0;
      for (int c = 0; c < LAT + 10; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (golden_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midreset_stale c=%0d: got gv=%b done=%b busy=%b want 0 0 0", c, golden_valid, done, busy);
         end
      end
      foreach (hit_tab[i]) hit_tab[i] = 1'b1;
      run_job("after_reset", 32'd7, 32'd9, 1'b0);
      n_vec++;
      if (obs_gold_cnt != 3) begin n_bad++; $display("FAIL after_reset_gold_cnt: got %0d want 3", obs_gold_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_golden();
      test_wrap();
      test_random();
      test_back_to_back();
      test_reset_midjob();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
